// File: rtl/vrf_bram_addr_gen_multilane_if.sv
// VRF BRAM address generator bus: decode-side request
// fields in, BRAM-side addresses, enables and lane masks out.
interface vrf_bram_addr_gen_multilane_if #(
  parameter int NUM_VREGS       = 32,
  parameter int ELEMS_PER_REG   = 32,
  parameter int LANES           = 1,
  parameter int MAX_EXE_LATENCY = 7
);
  localparam int RPR   = ELEMS_PER_REG / LANES;
  localparam int DEPTH = NUM_VREGS * RPR;
  localparam int AW    = $clog2(DEPTH);
  localparam int VLMAX = ELEMS_PER_REG * 8;
  localparam int VLW   = $clog2(VLMAX) + 1;
  localparam int MAW   = $clog2(VLMAX / LANES);
  localparam int LW    = $clog2(MAX_EXE_LATENCY + 1);
  localparam int RW    = $clog2(NUM_VREGS);

  logic             start_i;
  logic [1:0]       vrf_type_of_access_i;
  logic [RW-1:0]    vs1_address_i;
  logic [RW-1:0]    vs2_address_i;
  logic [RW-1:0]    vd_address_i;
  logic [1:0]       vmul_i;
  logic [VLW-1:0]   vector_length_i;
  logic [LW-1:0]    alu_exe_time_i;
  logic             stall_i;
  logic [AW-1:0]    BRAM1_r_address_o;
  logic             BRAM1_re_o;
  logic [AW-1:0]    BRAM2_r_address_o;
  logic             BRAM2_re_o;
  logic [AW-1:0]    BRAM_w_address_o;
  logic             BRAM_we_o;
  logic [MAW-1:0]   mask_BRAM_r_address_o;
  logic             mask_BRAM_re_o;
  logic [LANES-1:0] rd_lane_valid_o;
  logic [LANES-1:0] wr_lane_valid_o;
  logic             ready_o;

  modport master (
    output start_i, vrf_type_of_access_i,
    output vs1_address_i, vs2_address_i, vd_address_i,
    output vmul_i, vector_length_i, alu_exe_time_i,
    output stall_i,
    input  BRAM1_r_address_o, BRAM1_re_o,
    input  BRAM2_r_address_o, BRAM2_re_o,
    input  BRAM_w_address_o, BRAM_we_o,
    input  mask_BRAM_r_address_o, mask_BRAM_re_o,
    input  rd_lane_valid_o, wr_lane_valid_o, ready_o
  );

  modport slave (
    input  start_i, vrf_type_of_access_i,
    input  vs1_address_i, vs2_address_i, vd_address_i,
    input  vmul_i, vector_length_i, alu_exe_time_i,
    input  stall_i,
    output BRAM1_r_address_o, BRAM1_re_o,
    output BRAM2_r_address_o, BRAM2_re_o,
    output BRAM_w_address_o, BRAM_we_o,
    output mask_BRAM_r_address_o, mask_BRAM_re_o,
    output rd_lane_valid_o, wr_lane_valid_o, ready_o
  );
endinterface

// File: rtl/vrf_bram_addr_gen_multilane.sv
// VRF BRAM address sequencer: one tick counter drives read
// beat k at tick k and write beat k at tick k+L.
module vrf_bram_addr_gen_multilane #(
  parameter int NUM_VREGS       = 32,
  parameter int ELEMS_PER_REG   = 32,
  parameter int LANES           = 1,
  parameter int MAX_EXE_LATENCY = 7
) (
  input logic clk,
  input logic reset,
  vrf_bram_addr_gen_multilane_if.slave bus
);
  localparam int RPR   = ELEMS_PER_REG / LANES;
  localparam int DEPTH = NUM_VREGS * RPR;
  localparam int AW    = $clog2(DEPTH);
  localparam int VLMAX = ELEMS_PER_REG * 8;
  localparam int VLW   = $clog2(VLMAX) + 1;
  localparam int MAW   = $clog2(VLMAX / LANES);
  localparam int LW    = $clog2(MAX_EXE_LATENCY + 1);
  localparam int TW    = VLW + LW + 1;
  localparam int BW    = MAW + 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;

  localparam logic [1:0] T_VV = 2'b00;
  localparam logic [1:0] T_VX = 2'b01;
  localparam logic [1:0] T_WR = 2'b10;
  localparam logic [1:0] T_ST = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic [1:0]       typ_q, typ_d;
  logic [AW-1:0]    b1_q, b1_d, b2_q, b2_d, bw_q, bw_d;
  logic [VLW-1:0]   vl_q, vl_d;
  logic [BW-1:0]    beats_q, beats_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [TW-1:0]    last_q, last_d;
  logic [TW-1:0]    t_q, t_d;
  logic [AW-1:0]    r1a_q, r1a_d, r2a_q, r2a_d, wa_q, wa_d;
  logic             r1e_q, r1e_d, r2e_q, r2e_d, we_q, we_d;
  logic [MAW-1:0]   ma_q, ma_d;
  logic             me_q, me_d;
  logic [LANES-1:0] rlv_q, rlv_d, wlv_q, wlv_d;

  logic [VLW-1:0]   cap, vl_in;
  logic [BW-1:0]    beats_in;
  logic [LW-1:0]    lat_in;
  logic             accept, go, rd_on, wr_on;
  logic [TW-1:0]    tk, wk;

  function automatic logic [AW-1:0] row(
    input logic [AW-1:0] base,
    input logic [TW-1:0] k
  );
    logic [AW:0] s;
    s = {1'b0, base} + (AW+1)'(k);
    if (s >= (AW+1)'(DEPTH))
      s = s - (AW+1)'(DEPTH);
    return s[AW-1:0];
  endfunction

  // Partial mask on the final beat when vl is not lane-aligned.
  function automatic logic [LANES-1:0] lmask(
    input logic [TW-1:0]  k,
    input logic [BW-1:0]  beats,
    input logic [VLW-1:0] vl
  );
    int rem;
    rem = int'(vl) % LANES;
    lmask = '1;
    if (k == TW'(beats) - TW'(1) && rem != 0)
      lmask = LANES'((1 << rem) - 1);
  endfunction

  // Request decode, op latch, beat emission and FSM next state.
  always_comb begin
    cap = VLW'(ELEMS_PER_REG) << bus.vmul_i;
    vl_in = (bus.vector_length_i < cap) ?
            bus.vector_length_i : cap;
    beats_in = BW'((int'(vl_in) + LANES - 1) / LANES);
    lat_in = (bus.alu_exe_time_i > LW'(MAX_EXE_LATENCY)) ?
             LW'(MAX_EXE_LATENCY) : bus.alu_exe_time_i;
    if (bus.vrf_type_of_access_i[1])
      lat_in = '0;
    accept = bus.start_i & ready_q;

    typ_d   = typ_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    bw_d    = bw_q;
    vl_d    = vl_q;
    beats_d = beats_q;
    lat_d   = lat_q;
    last_d  = last_q;
    if (accept) begin
      typ_d   = bus.vrf_type_of_access_i;
      b1_d    = AW'(int'(bus.vs1_address_i) * RPR);
      b2_d    = AW'(int'(bus.vs2_address_i) * RPR);
      bw_d    = AW'(int'(bus.vd_address_i) * RPR);
      vl_d    = vl_in;
      beats_d = beats_in;
      lat_d   = lat_in;
      last_d  = TW'(beats_in) + TW'(lat_in) - TW'(1);
    end

    tk = accept ? '0 : t_q;
    go = accept ? (beats_in != '0) :
         (state_q != IDLE && !bus.stall_i && t_q <= last_q);
    wk = tk - TW'(lat_d);
    rd_on = go && tk < TW'(beats_d);
    wr_on = go && tk >= TW'(lat_d) && wk < TW'(beats_d);

    r1e_d = rd_on && (typ_d == T_VV || typ_d == T_ST);
    r2e_d = rd_on && (typ_d == T_VV || typ_d == T_VX);
    we_d  = wr_on && typ_d != T_ST;
    me_d  = (typ_d == T_WR) ? we_d : rd_on;
    rlv_d = (r1e_d | r2e_d) ? lmask(tk, beats_d, vl_d) : '0;
    wlv_d = we_d ? lmask(wk, beats_d, vl_d) : '0;
    r1a_d = r1e_d ?
            row((typ_d == T_ST) ? bw_d : b1_d, tk) : r1a_q;
    r2a_d = r2e_d ? row(b2_d, tk) : r2a_q;
    wa_d  = we_d ? row(bw_d, wk) : wa_q;
    ma_d  = me_d ?
            MAW'((typ_d == T_WR) ? wk : tk) : ma_q;

    state_d = state_q;
    ready_d = ready_q;
    t_d     = t_q;
    if (accept) begin
      if (beats_in != '0) begin
        state_d = RUN;
        ready_d = 1'b0;
        t_d     = TW'(1);
      end
    end else if (state_q != IDLE) begin
      if (t_q > last_q) begin
        state_d = IDLE;
        ready_d = 1'b1;
        t_d     = '0;
      end else if (!bus.stall_i) begin
        t_d     = t_q + TW'(1);
        state_d = (t_d < TW'(beats_q)) ? RUN : DRAIN;
      end
    end
  end

  // State, latched op and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      typ_q   <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      bw_q    <= '0;
      vl_q    <= '0;
      beats_q <= '0;
      lat_q   <= '0;
      last_q  <= '0;
      t_q     <= '0;
      r1a_q   <= '0;
      r2a_q   <= '0;
      wa_q    <= '0;
      r1e_q   <= 1'b0;
      r2e_q   <= 1'b0;
      we_q    <= 1'b0;
      ma_q    <= '0;
      me_q    <= 1'b0;
      rlv_q   <= '0;
      wlv_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      typ_q   <= typ_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      bw_q    <= bw_d;
      vl_q    <= vl_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      t_q     <= t_d;
      r1a_q   <= r1a_d;
      r2a_q   <= r2a_d;
      wa_q    <= wa_d;
      r1e_q   <= r1e_d;
      r2e_q   <= r2e_d;
      we_q    <= we_d;
      ma_q    <= ma_d;
      me_q    <= me_d;
      rlv_q   <= rlv_d;
      wlv_q   <= wlv_d;
    end
  end

  assign bus.BRAM1_r_address_o     = r1a_q;
  assign bus.BRAM1_re_o            = r1e_q;
  assign bus.BRAM2_r_address_o     = r2a_q;
  assign bus.BRAM2_re_o            = r2e_q;
  assign bus.BRAM_w_address_o      = wa_q;
  assign bus.BRAM_we_o             = we_q;
  assign bus.mask_BRAM_r_address_o = ma_q;
  assign bus.mask_BRAM_re_o        = me_q;
  assign bus.rd_lane_valid_o       = rlv_q;
  assign bus.wr_lane_valid_o       = wlv_q;
  assign bus.ready_o               = ready_q;
endmodule

// File: tb/tb_vrf_bram_addr_gen_multilane.sv
// Directed bench for the VRF BRAM address sequencer,
// LANES=1 and LANES=4 builds side by side.
module tb_vrf_bram_addr_gen_multilane;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n1, n2, nw, bad, rdy_at, probe, q;

  vrf_bram_addr_gen_multilane_if #(.LANES(1)) b1();
  vrf_bram_addr_gen_multilane_if #(.LANES(4)) b4();

  vrf_bram_addr_gen_multilane #(.LANES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );
  vrf_bram_addr_gen_multilane #(.LANES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic issue1(input int typ, vs1, vs2, vd,
                        input int vmul, vl, lat);
    @(negedge clk);
    b1.vrf_type_of_access_i = 2'(typ);
    b1.vs1_address_i = 5'(vs1);
    b1.vs2_address_i = 5'(vs2);
    b1.vd_address_i = 5'(vd);
    b1.vmul_i = 2'(vmul);
    b1.vector_length_i = 9'(vl);
    b1.alu_exe_time_i = 3'(lat);
    b1.start_i = 1'b1;
    @(posedge clk);
    #1;
    b1.start_i = 1'b0;
    b1.vrf_type_of_access_i = 2'(3 - typ);
    b1.vs1_address_i = 5'd7;
    b1.vs2_address_i = 5'd9;
    b1.vd_address_i = 5'd11;
    b1.vmul_i = 2'd0;
    b1.vector_length_i = 9'd3;
    b1.alu_exe_time_i = 3'd0;
  endtask

  task automatic run_op(input int typ, vs1, vs2, vd,
                        input int vmul, vl, lat,
                        input int st_at, st_len, pk);
    int vle, beats, le, last, tick, lim, wk, scnt;
    int a1, a2, aw, am;
    bit sp, rd, wr, e1, e2, ew, em, kick;
    vle = 32 << vmul;
    if (vl < vle) vle = vl;
    beats = vle;
    le = (typ >= 2) ? 0 : ((lat > 7) ? 7 : lat);
    last = beats - 1 + le;
    n1 = 0; n2 = 0; nw = 0; bad = 0;
    rdy_at = -1; probe = -1;
    tick = 0; sp = 0; scnt = 0;
    lim = last + st_len + 8;
    issue1(typ, vs1, vs2, vd, vmul, vl, lat);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      kick = 0;
      n1 += int'(b1.BRAM1_re_o);
      n2 += int'(b1.BRAM2_re_o);
      nw += int'(b1.BRAM_we_o);
      a1 = int'(b1.BRAM1_r_address_o);
      a2 = int'(b1.BRAM2_r_address_o);
      aw = int'(b1.BRAM_w_address_o);
      am = int'(b1.mask_BRAM_r_address_o);
      if (sp) begin
        if (b1.BRAM1_re_o || b1.BRAM2_re_o ||
            b1.BRAM_we_o || b1.mask_BRAM_re_o) bad++;
      end else if (tick <= last) begin
        rd = tick < beats;
        wk = tick - le;
        wr = tick >= le && wk < beats;
        e1 = rd && (typ == 0 || typ == 3);
        e2 = rd && typ <= 1;
        ew = wr && typ != 3;
        em = (typ == 2) ? ew : rd;
        if (b1.BRAM1_re_o != e1 || b1.BRAM2_re_o != e2 ||
            b1.BRAM_we_o != ew || b1.mask_BRAM_re_o != em)
          bad++;
        if (e1 && a1 != (((typ == 3) ? vd : vs1) * 32
                          + tick) % 1024) bad++;
        if (e2 && a2 != (vs2 * 32 + tick) % 1024) bad++;
        if (ew && aw != (vd * 32 + wk) % 1024) bad++;
        if (em && am != ((typ == 2) ? wk : tick)) bad++;
        if (b1.rd_lane_valid_o != (e1 | e2)) bad++;
        if (b1.wr_lane_valid_o != ew) bad++;
        if (b1.ready_o) bad++;
        if ((e1 | e2) && tick == pk) probe = e1 ? a1 : a2;
        if (tick == st_at) scnt = st_len;
        kick = (tick == 5);
        tick++;
      end else if (b1.ready_o) begin
        rdy_at = c;
        break;
      end
      sp = scnt > 0;
      if (scnt > 0) scnt--;
      b1.stall_i = sp;
      b1.start_i = kick;
    end
    b1.stall_i = 1'b0;
    b1.start_i = 1'b0;
  endtask

  int erl[5] = '{15, 15, 3, 0, 0};
  int ewl[5] = '{0, 15, 15, 3, 0};
  int erd[5] = '{0, 0, 0, 0, 1};

  initial begin
    #5_000_000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    b1.start_i = 1'b0; b1.stall_i = 1'b0;
    b1.vrf_type_of_access_i = 2'd0;
    b1.vs1_address_i = '0; b1.vs2_address_i = '0;
    b1.vd_address_i = '0; b1.vmul_i = '0;
    b1.vector_length_i = '0; b1.alu_exe_time_i = '0;
    b4.start_i = 1'b0; b4.stall_i = 1'b0;
    b4.vrf_type_of_access_i = 2'd0;
    b4.vs1_address_i = '0; b4.vs2_address_i = '0;
    b4.vd_address_i = '0; b4.vmul_i = '0;
    b4.vector_length_i = '0; b4.alu_exe_time_i = '0;
    #1;
    chk("rst_rdy", int'(b1.ready_o), 1);
    chk("rst_en", int'({b1.BRAM1_re_o, b1.BRAM2_re_o,
        b1.BRAM_we_o, b1.mask_BRAM_re_o}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // vv, L=4
    run_op(0, 0, 1, 2, 0, 32, 4, -1, 0, 0);
    chk("t1_n1", n1, 32);
    chk("t1_n2", n2, 32);
    chk("t1_nw", nw, 32);
    chk("t1_seq", bad, 0);
    chk("t1_rdy", rdy_at, 37);
    chk("t1_first", probe, 0);

    // vx, LMUL=2, wraps past row 1023
    run_op(1, 3, 31, 0, 1, 64, 2, -1, 0, 32);
    chk("t2_n1", n1, 0);
    chk("t2_n2", n2, 64);
    chk("t2_nw", nw, 64);
    chk("t2_seq", bad, 0);
    chk("t2_wrap", probe, 0);
    chk("t2_rdy", rdy_at, 67);

    // LANES=4, partial last beat
    @(negedge clk);
    b4.vrf_type_of_access_i = 2'd0;
    b4.vs1_address_i = 5'd0;
    b4.vs2_address_i = 5'd1;
    b4.vd_address_i = 5'd2;
    b4.vmul_i = 2'd0;
    b4.vector_length_i = 9'd10;
    b4.alu_exe_time_i = 3'd1;
    b4.start_i = 1'b1;
    @(posedge clk);
    #1 b4.start_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("l4_rlv", int'(b4.rd_lane_valid_o), erl[c]);
      chk("l4_wlv", int'(b4.wr_lane_valid_o), ewl[c]);
      chk("l4_rdy", int'(b4.ready_o), erd[c]);
      if (c == 0) chk("l4_a2", int'(b4.BRAM2_r_address_o), 8);
      if (c == 2) chk("l4_a1", int'(b4.BRAM1_r_address_o), 2);
      if (c == 3) chk("l4_aw", int'(b4.BRAM_w_address_o), 18);
    end

    // stall for 3 cycles after beat 2
    run_op(0, 4, 5, 6, 0, 8, 3, 2, 3, 3);
    chk("t4_n1", n1, 8);
    chk("t4_nw", nw, 8);
    chk("t4_seq", bad, 0);
    chk("t4_beat3", probe, 131);
    chk("t4_rdy", rdy_at, 15);

    // vl=0: accepted, nothing issued
    @(negedge clk);
    b1.vrf_type_of_access_i = 2'd0;
    b1.vector_length_i = 9'd0;
    b1.start_i = 1'b1;
    @(posedge clk);
    #1 b1.start_i = 1'b0;
    q = 0;
    repeat (4) begin
      @(negedge clk);
      if (b1.BRAM1_re_o || b1.BRAM2_re_o || b1.BRAM_we_o ||
          b1.mask_BRAM_re_o || !b1.ready_o) q++;
    end
    chk("vl0_quiet", q, 0);

    // vl=300, LMUL=8 clamps to 256 beats
    run_op(0, 0, 8, 16, 3, 300, 7, -1, 0, 255);
    chk("t5_n1", n1, 256);
    chk("t5_nw", nw, 256);
    chk("t5_seq", bad, 0);
    chk("t5_last", probe, 255);
    chk("t5_rdy", rdy_at, 264);

    // store: read vd only, L ignored
    run_op(3, 9, 10, 5, 0, 16, 5, -1, 0, 0);
    chk("st_n1", n1, 16);
    chk("st_n2", n2, 0);
    chk("st_nw", nw, 0);
    chk("st_seq", bad, 0);
    chk("st_first", probe, 160);
    chk("st_rdy", rdy_at, 17);

    // write-only: L forced to 0
    run_op(2, 1, 2, 3, 0, 4, 6, -1, 0, 0);
    chk("wo_nrd", n1 + n2, 0);
    chk("wo_nw", nw, 4);
    chk("wo_seq", bad, 0);
    chk("wo_rdy", rdy_at, 5);

    // async reset mid-op, then a clean op
    issue1(0, 0, 1, 2, 0, 32, 0);
    repeat (11) @(negedge clk);
    chk("pre_rst_busy", int'(b1.ready_o), 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_en", int'({b1.BRAM1_re_o, b1.BRAM2_re_o,
        b1.BRAM_we_o, b1.mask_BRAM_re_o}), 0);
    chk("mid_rst_addr", int'(b1.BRAM1_r_address_o) +
        int'(b1.BRAM2_r_address_o) +
        int'(b1.BRAM_w_address_o) +
        int'(b1.mask_BRAM_r_address_o), 0);
    chk("mid_rst_rdy", int'(b1.ready_o), 1);
    @(negedge clk);
    reset = 1'b0;
    run_op(0, 1, 2, 3, 0, 32, 1, -1, 0, 0);
    chk("t6_n1", n1, 32);
    chk("t6_nw", nw, 32);
    chk("t6_seq", bad, 0);
    chk("t6_first", probe, 32);
    chk("t6_rdy", rdy_at, 34);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
